fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of issue lanes per bundle (lane 0 oldest).
REQ-002 SHALL have parameter AW, default 3, meaning register address width.
REQ-003 SHALL have parameter DW, default 16, meaning data width.
REQ-004 SHALL have parameter DEPTH, default 2, range 2..4, meaning in-flight stages after EX that are tracked.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous invalidate of all tracked stages.
REQ-008 ex_valid  input  LANES  lane holds a real instruction in EX.
REQ-009 ex_we  input  LANES  lane writes a register.
REQ-010 ex_rd  input  LANES*AW  destination per lane.
REQ-011 ex_result  input  LANES*DW  ALU result per lane.
REQ-012 ex_is_load  input  LANES  result comes from memory, not ALU.
REQ-013 ex_flag_we, ex_flag  input  LANES each  N-flag write enable and value per lane.
REQ-014 ex_rs  input  LANES*2*AW  two source addresses per lane.
REQ-015 ex_rf  input  LANES*2*DW  register-file values for those sources.
REQ-016 mem_load_data  input  LANES*DW  load data for the entry in stage 1.
REQ-017 opnd  output  LANES*2*DW  resolved operand values.
REQ-018 fwd_hit  output  LANES*2  operand taken from a tracked stage.
REQ-019 stall  output  1  load-use hazard; hold EX one cycle.
REQ-020 flag_out  output  1  newest N flag.

Function
REQ-021 Stage k (1..DEPTH) SHALL register per lane: valid, we, rd, data, is_load, flag_we, flag; stage 1 loads from EX, stage k+1 from stage k, every cycle.
REQ-022 On stage 1→2 transfer, data SHALL be replaced by mem_load_data when is_load=1.
REQ-023 Entry matches operand when valid&&we&&rd==src&&src!=0.
REQ-024 Priority SHALL be: stage 1 over stage 2 over ... stage DEPTH; within a stage higher lane index wins.
REQ-025 No match → opnd=ex_rf, fwd_hit=0; match → opnd=entry data, fwd_hit=1; combinational, zero latency.
REQ-026 Source register 0 SHALL never forward.
REQ-027 stall=1 when any ex_valid lane operand's winning match is a stage-1 load; winner selection is still per REQ-024.
REQ-028 When stall=1, stage 1 SHALL load an all-invalid bubble; older stages still advance.
REQ-029 Same-bundle dependency (lane j reads rd of lane i<j) SHALL NOT forward; caller resolves it.
REQ-030 Architectural flag register SHALL update from stage DEPTH, highest lane with valid&&flag_we.
REQ-031 flag_out = flag of newest valid flag_we entry (stage 1 lane max first, EX lanes excluded), else architectural flag.
REQ-032 flush=1 SHALL clear all stage valid bits at the edge; architectural flag unchanged; flush over stall.

Reset
REQ-033 rst_n=0 SHALL immediately clear all stage valid bits and the architectural flag, independent of clk.
REQ-034 During and after reset: stall=0, fwd_hit=0, opnd=ex_rf, flag_out=0 until a flag writer enters stage 1.
REQ-035 Reset mid-stall SHALL drop the pending bubble; first post-reset cycle has no hazard.

Verification
REQ-036 Lane0 ALU writes r3=0x1234, next cycle lane1 reads r3 → opnd=0x1234, fwd_hit=1, stall=0.
REQ-037 r3 written in stage 2 (0x1111) and stage 1 (0x2222) → 0x2222; both lanes of stage 1 write r3 → lane 1 value.
REQ-038 Load r5 then immediate consumer of r5 → stall=1 one cycle; next cycle opnd=mem_load_data (e.g. 0xBEEF), stall=0.
REQ-039 Writer to r0 with 0xFFFF, consumer reads r0, ex_rf=0 → opnd=0, fwd_hit=0.
REQ-040 Lane1 flag write 1, then flush → flag_out=0; flag write reaching stage DEPTH without flush → flag_out stays 1 after drain.
REQ-041 Assert rst_n=0 asynchronously with full stages → all fwd_hit=0 before next clk edge.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Result-forwarding scoreboard: tracks DEPTH post-EX stages per lane, resolves operands combinationally.
// Zero-latency operand resolution; stall requests a one-cycle EX hold on a stage-1 load-use hazard.
module fwd_scoreboard #(
   parameter int LANES = 2,
   parameter int AW    = 3,
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [LANES-1:0]        ex_valid,
   input  logic [LANES-1:0]        ex_we,
   input  logic [LANES*AW-1:0]     ex_rd,
   input  logic [LANES*DW-1:0]     ex_result,
   input  logic [LANES-1:0]        ex_is_load,
   input  logic [LANES-1:0]        ex_flag_we,
   input  logic [LANES-1:0]        ex_flag,
   input  logic [LANES*2*AW-1:0]   ex_rs,
   input  logic [LANES*2*DW-1:0]   ex_rf,
   input  logic [LANES*DW-1:0]     mem_load_data,
   output logic [LANES*2*DW-1:0]   opnd,
   output logic [LANES*2-1:0]      fwd_hit,
   output logic                    stall,
   output logic                    flag_out
);

   // Index 0 is stage 1 (youngest), index DEPTH-1 is stage DEPTH (oldest).
   logic [LANES-1:0]    r_vld [DEPTH];
   logic [LANES-1:0]    r_we  [DEPTH];
   logic [LANES-1:0]    r_ld  [DEPTH];
   logic [LANES-1:0]    r_fwe [DEPTH];
   logic [LANES-1:0]    r_flg [DEPTH];
   logic [LANES*AW-1:0] r_rd  [DEPTH];
   logic [LANES*DW-1:0] r_dat [DEPTH];
   logic                r_aflag;

   logic [AW-1:0]       w_src;
   logic                w_ld_win;
   logic [LANES*DW-1:0] w_ld_dat;
   logic                w_ret_vld;
   logic                w_ret_flag;

   // Scan oldest to youngest, low lane to high: the last match is the winner.
   always_comb begin
      opnd     = ex_rf;
      fwd_hit  = '0;
      stall    = 1'b0;
      w_src    = '0;
      w_ld_win = 1'b0;
      for (int o = 0; o < LANES*2; o++) begin
         w_src    = ex_rs[o*AW +: AW];
         w_ld_win = 1'b0;
         for (int k = DEPTH-1; k >= 0; k--) begin
            for (int l = 0; l < LANES; l++) begin
               if (r_vld[k][l] && r_we[k][l] && (r_rd[k][l*AW +: AW] == w_src) && (w_src != '0)) begin
                  opnd[o*DW +: DW] = r_dat[k][l*DW +: DW];
                  fwd_hit[o]       = 1'b1;
                  w_ld_win         = (k == 0) && r_ld[k][l];
               end
            end
         end
         if (w_ld_win && ex_valid[o/2]) stall = 1'b1;
      end
   end

   always_comb begin
      flag_out = r_aflag;
      for (int k = DEPTH-1; k >= 0; k--) begin
         for (int l = 0; l < LANES; l++) begin
            if (r_vld[k][l] && r_fwe[k][l]) flag_out = r_flg[k][l];
         end
      end
   end

   always_comb begin
      w_ret_vld  = 1'b0;
      w_ret_flag = r_aflag;
      w_ld_dat   = r_dat[0];
      for (int l = 0; l < LANES; l++) begin
         if (r_vld[DEPTH-1][l] && r_fwe[DEPTH-1][l]) begin
            w_ret_vld  = 1'b1;
            w_ret_flag = r_flg[DEPTH-1][l];
         end
         if (r_ld[0][l]) w_ld_dat[l*DW +: DW] = mem_load_data[l*DW +: DW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_vld[k] <= '0;
            r_we[k]  <= '0;
            r_ld[k]  <= '0;
            r_fwe[k] <= '0;
            r_flg[k] <= '0;
            r_rd[k]  <= '0;
            r_dat[k] <= '0;
         end
         r_aflag <= 1'b0;
      end else begin
         r_vld[0] <= (flush || stall) ? '0 : ex_valid;
         r_we[0]  <= ex_we;
         r_ld[0]  <= ex_is_load;
         r_fwe[0] <= ex_flag_we;
         r_flg[0] <= ex_flag;
         r_rd[0]  <= ex_rd;
         r_dat[0] <= ex_result;
         r_dat[1] <= w_ld_dat;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k] <= flush ? '0 : r_vld[k-1];
            r_we[k]  <= r_we[k-1];
            r_ld[k]  <= r_ld[k-1];
            r_fwe[k] <= r_fwe[k-1];
            r_flg[k] <= r_flg[k-1];
            r_rd[k]  <= r_rd[k-1];
         end
         for (int k = 2; k < DEPTH; k++) r_dat[k] <= r_dat[k-1];
         // A flushed retirement does not commit its flag.
         if (!flush && w_ret_vld) r_aflag <= w_ret_flag;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus randomized traffic against an age-ordered reference model.
module tb_fwd_scoreboard;
   localparam int LANES = 2;
   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 2;

   logic                  clk, rst_n, flush;
   logic [LANES-1:0]      ex_valid, ex_we, ex_is_load, ex_flag_we, ex_flag;
   logic [LANES*AW-1:0]   ex_rd;
   logic [LANES*DW-1:0]   ex_result, mem_load_data;
   logic [LANES*2*AW-1:0] ex_rs;
   logic [LANES*2*DW-1:0] ex_rf;
   logic [LANES*2*DW-1:0] opnd;
   logic [LANES*2-1:0]    fwd_hit;
   logic                  stall, flag_out;

   fwd_scoreboard #(.LANES(LANES), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd), .ex_result(ex_result),
      .ex_is_load(ex_is_load), .ex_flag_we(ex_flag_we), .ex_flag(ex_flag),
      .ex_rs(ex_rs), .ex_rf(ex_rf), .mem_load_data(mem_load_data),
      .opnd(opnd), .fwd_hit(fwd_hit), .stall(stall), .flag_out(flag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           v, we, ld, fwe, flg;
      bit [AW-1:0]  rd;
      bit [DW-1:0]  dat;
   } ent_t;

   // pipe[age][lane]; age 0 is the newest bundle in flight.
   ent_t pipe [DEPTH][LANES];
   bit   aflag;
   bit   exp_stall;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++)
         for (int l = 0; l < LANES; l++) pipe[a][l].v = 1'b0;
      aflag     = 1'b0;
      exp_stall = 1'b0;
   endtask

   // Newest bundle first, highest lane first; first match wins.
   function automatic void resolve(input logic [AW-1:0] src, input logic [DW-1:0] rf,
                                   output logic [DW-1:0] d, output logic h, output logic ld0);
      d = rf; h = 1'b0; ld0 = 1'b0;
      if (src == 0) return;
      for (int a = 0; a < DEPTH; a++)
         for (int l = LANES-1; l >= 0; l--)
            if (pipe[a][l].v && pipe[a][l].we && pipe[a][l].rd == src) begin
               d = pipe[a][l].dat; h = 1'b1; ld0 = (a == 0) && pipe[a][l].ld;
               return;
            end
   endfunction

   function automatic bit model_flag();
      for (int a = 0; a < DEPTH; a++)
         for (int l = LANES-1; l >= 0; l--)
            if (pipe[a][l].v && pipe[a][l].fwe) return pipe[a][l].flg;
      return aflag;
   endfunction

   task automatic check_all();
      logic [DW-1:0] d;
      logic h, ld0, st;
      #1;
      st = 1'b0;
      for (int o = 0; o < LANES*2; o++) begin
         resolve(ex_rs[o*AW +: AW], ex_rf[o*DW +: DW], d, h, ld0);
         chk($sformatf("opnd%0d", o), 64'(opnd[o*DW +: DW]), 64'(d));
         chk($sformatf("fwd_hit%0d", o), 64'(fwd_hit[o]), 64'(h));
         if (h && ld0 && ex_valid[o/2]) st = 1'b1;
      end
      chk("stall", 64'(stall), 64'(st));
      chk("flag_out", 64'(flag_out), 64'(model_flag()));
      exp_stall = st;
   endtask

   task automatic model_update();
      if (!flush)
         for (int l = 0; l < LANES; l++)
            if (pipe[DEPTH-1][l].v && pipe[DEPTH-1][l].fwe) aflag = pipe[DEPTH-1][l].flg;
      for (int a = DEPTH-1; a >= 1; a--)
         for (int l = 0; l < LANES; l++) begin
            pipe[a][l] = pipe[a-1][l];
            if (a == 1 && pipe[1][l].ld) pipe[1][l].dat = mem_load_data[l*DW +: DW];
         end
      for (int l = 0; l < LANES; l++) begin
         pipe[0][l].v   = ex_valid[l] && !exp_stall;
         pipe[0][l].we  = ex_we[l];
         pipe[0][l].ld  = ex_is_load[l];
         pipe[0][l].fwe = ex_flag_we[l];
         pipe[0][l].flg = ex_flag[l];
         pipe[0][l].rd  = ex_rd[l*AW +: AW];
         pipe[0][l].dat = ex_result[l*DW +: DW];
      end
      if (flush)
         for (int a = 0; a < DEPTH; a++)
            for (int l = 0; l < LANES; l++) pipe[a][l].v = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      @(negedge clk);
   endtask

   task automatic step();
      check_all();
      tick();
   endtask

   task automatic clr();
      flush = 0; ex_valid = '0; ex_we = '0; ex_rd = '0; ex_result = '0; ex_is_load = '0;
      ex_flag_we = '0; ex_flag = '0; ex_rs = '0; ex_rf = '0; mem_load_data = '0;
   endtask

   task automatic wr(input int l, input logic [AW-1:0] rd, input logic [DW-1:0] val, input bit ld);
      ex_valid[l] = 1'b1; ex_we[l] = 1'b1; ex_rd[l*AW +: AW] = rd;
      ex_result[l*DW +: DW] = val; ex_is_load[l] = ld;
   endtask

   task automatic rd_src(input int l, input int s, input logic [AW-1:0] rs, input logic [DW-1:0] rf);
      ex_valid[l] = 1'b1;
      ex_rs[(l*2+s)*AW +: AW] = rs;
      ex_rf[(l*2+s)*DW +: DW] = rf;
   endtask

   task automatic async_reset();
      #1 rst_n = 1'b0;
      model_reset();
      check_all();
      chk("rst_fwd_hit", 64'(fwd_hit), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_flag", 64'(flag_out), 64'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] r;
      rst_n = 1'b0;
      clr();
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      chk("reset_hit", 64'(fwd_hit), 64'h0);
      rst_n = 1'b1;
      tick();

      // ALU result forwarded to the next bundle.
      clr(); wr(0, 3, 16'h1234, 0); step();
      clr(); rd_src(1, 0, 3, 16'hAAAA); check_all();
      chk("alu_fwd", 64'(opnd[2*DW +: DW]), 64'h1234);
      chk("alu_hit", 64'(fwd_hit[2]), 64'h1);
      chk("alu_stall", 64'(stall), 64'h0);
      tick();

      // Younger stage beats older; higher lane beats lower in one stage.
      clr(); wr(0, 3, 16'h1111, 0); step();
      clr(); wr(0, 3, 16'h2222, 0); step();
      clr(); rd_src(0, 1, 3, 16'h0); check_all();
      chk("stage_prio", 64'(opnd[1*DW +: DW]), 64'h2222);
      tick();
      clr(); wr(0, 3, 16'h0A0A, 0); wr(1, 3, 16'h0B0B, 0); step();
      clr(); rd_src(0, 0, 3, 16'h0); check_all();
      chk("lane_prio", 64'(opnd[0 +: DW]), 64'h0B0B);
      tick();

      // Load-use: one stall cycle, then the load data is forwarded.
      clr(); wr(0, 5, 16'h0000, 1); step();
      clr(); rd_src(1, 1, 5, 16'h5555); mem_load_data[0 +: DW] = 16'hBEEF; check_all();
      chk("ld_stall", 64'(stall), 64'h1);
      tick();
      check_all();
      chk("ld_stall_clear", 64'(stall), 64'h0);
      chk("ld_data", 64'(opnd[3*DW +: DW]), 64'hBEEF);
      tick();

      // r0 is never forwarded.
      clr(); wr(0, 0, 16'hFFFF, 0); step();
      clr(); rd_src(1, 0, 0, 16'h0); check_all();
      chk("r0_opnd", 64'(opnd[2*DW +: DW]), 64'h0);
      chk("r0_hit", 64'(fwd_hit[2]), 64'h0);
      tick();

      // Flag: flushed writer is lost; drained writer commits.
      clr(); ex_valid[1] = 1; ex_flag_we[1] = 1; ex_flag[1] = 1; step();
      clr(); flush = 1; check_all();
      chk("flag_pre_flush", 64'(flag_out), 64'h1);
      tick();
      clr(); check_all();
      chk("flag_flushed", 64'(flag_out), 64'h0);
      tick();
      clr(); ex_valid[1] = 1; ex_flag_we[1] = 1; ex_flag[1] = 1; step();
      clr(); repeat (DEPTH) step();
      check_all();
      chk("flag_drained", 64'(flag_out), 64'h1);
      tick();

      // Async reset with full stages clears forwarding immediately.
      clr(); wr(0, 1, 16'h1111, 0); wr(1, 2, 16'h2222, 0); step();
      clr(); wr(0, 1, 16'h3333, 0); wr(1, 2, 16'h4444, 0); step();
      clr(); rd_src(0, 0, 1, 16'h00AA); rd_src(1, 0, 2, 16'h00BB); check_all();
      chk("pre_rst_hit", 64'(fwd_hit), 64'h5);
      async_reset();
      chk("rst_opnd", 64'(opnd), 64'(ex_rf));
      tick();

      // Reset during a stall drops the bubble.
      clr(); wr(0, 5, 16'h0, 1); step();
      clr(); rd_src(0, 0, 5, 16'h0); check_all();
      chk("pend_stall", 64'(stall), 64'h1);
      async_reset();
      tick();
      check_all();
      chk("post_rst_stall", 64'(stall), 64'h0);
      tick();

      for (int i = 0; i < 400; i++) begin
         r = $urandom; ex_valid = r[1:0]; ex_we = r[3:2]; ex_is_load = r[5:4] & r[7:6];
         ex_flag_we = r[9:8]; ex_flag = r[11:10]; ex_rd = r[17:12]; ex_rs = r[29:18];
         flush = ($urandom_range(0, 11) == 0);
         ex_result = $urandom; mem_load_data = $urandom;
         ex_rf = {$urandom, $urandom};
         if ($urandom_range(0, 63) == 0) async_reset();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
